// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage program counter and instruction fetch sequencer.
// Owns the architectural PC, fetches from instruction ROM one request at a
// time, and presents fetched words to the IF/ID register. Branch/jump
// redirects from ID follow MIPS delay-slot rules; exception flushes have
// priority over branches. Wrong-path fetches already in flight are discarded.
//
// ROM handshake: rom_req/rom_addr are a request offer; the fetch is accepted
// on a cycle where rom_req=1 and rom_gnt=1. Exactly one rom_rvalid follows
// each accepted request, at least one cycle later and in order; rom_rdata is
// meaningful only while rom_rvalid=1. rom_req is never raised while a
// response is still owed, so at most one fetch is outstanding.
module fetch_pc_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_gnt,
    input  logic              rom_rvalid,
    input  logic [ADDR_W-1:0] rom_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_addr,
    output logic [ADDR_W-1:0] if_inst
);

    // REQ : offering a fetch of pc
    // WAIT: one fetch outstanding, its data is on the correct path
    // HOLD: response captured in the skid buffer while IF/ID is stalled
    // DROP: one fetch outstanding, its data is wrong-path and will be dropped
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;

    // Skid buffer for a response that arrives while IF/ID is held
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [ADDR_W-1:0] buf_inst;

    // Redirect decode: a flush always wins; a branch only counts when ID
    // is actually advancing, otherwise ID will present it again.
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic              req_phase;
    logic              buf_load;
    logic              buf_clear;
    logic              deliver_rsp;
    logic              deliver_buf;

    assign redirect    = flush | (branch_flag & ~stall);
    assign redirect_pc = flush ? exc_pc : branch_addr;

    // Next-state, next-pc and datapath strobes for the fetch sequencer
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fetch_pc_next = fetch_pc;
        req_phase     = 1'b0;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        deliver_rsp   = 1'b0;
        deliver_buf   = 1'b0;

        unique case (state)
            ST_REQ: begin
                req_phase = 1'b1;
                if (rom_gnt) begin
                    fetch_pc_next = pc;
                    pc_next       = pc + PC_STEP;
                    // A fetch granted in the redirect cycle is already stale
                    state_next    = redirect ? ST_DROP : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (rom_rvalid) begin
                    if (redirect) begin
                        // Arrived together with the redirect: wrong-path
                        state_next = ST_REQ;
                    end else if (stall) begin
                        buf_load   = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        deliver_rsp = 1'b1;
                        state_next  = ST_REQ;
                    end
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    buf_clear  = 1'b1;
                    state_next = ST_REQ;
                end else if (!stall) begin
                    deliver_buf = buf_valid;
                    buf_clear   = 1'b1;
                    state_next  = ST_REQ;
                end
            end

            ST_DROP: begin
                if (rom_rvalid) begin
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_REQ;
            end
        endcase

        // The redirect target overrides the sequential pc+4 step
        if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    // Request is masked during reset so nothing is offered to the ROM
    assign rom_req  = req_phase & ~rst;
    assign rom_addr = pc;

    // Sequencer state, architectural PC and address of the outstanding fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            pc       <= RESET_PC;
            fetch_pc <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // Skid buffer: capture a response that IF/ID cannot take yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_inst  <= '0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_addr  <= fetch_pc;
            buf_inst  <= rom_rdata;
        end else if (buf_clear) begin
            buf_valid <= 1'b0;
        end
    end

    // IF/ID slot: a flush invalidates it even under stall; otherwise it only
    // changes when a correct-path word is handed over with stall=0. With no
    // new word the slot keeps its contents, which also keeps the delay slot
    // intact in a branch cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_addr  <= '0;
            if_inst  <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (deliver_rsp) begin
            if_valid <= 1'b1;
            if_addr  <= fetch_pc;
            if_inst  <= rom_rdata;
        end else if (deliver_buf) begin
            if_valid <= 1'b1;
            if_addr  <= buf_addr;
            if_inst  <= buf_inst;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: randomized bench for fetch_pc_unit with a ROM responder
// and a path-level model of which fetched words must reach IF/ID.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        rom_gnt = 1'b0;
  logic        rom_rvalid = 1'b0;
  logic [31:0] rom_rdata = '0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        if_valid;
  logic [31:0] if_addr;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .exc_pc      (exc_pc),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_gnt     (rom_gnt),
    .rom_rvalid  (rom_rvalid),
    .rom_rdata   (rom_rdata),
    .if_valid    (if_valid),
    .if_addr     (if_addr),
    .if_inst     (if_inst)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;

  // Correct-path addresses fetched (granted or buffered) but not yet in IF/ID
  logic [31:0] exp_q[$];

  // Model state
  logic [31:0] m_pc;        // address the next fetch must use
  bit          m_busy;      // the DUT is owed a response
  bit          m_held;      // a correct-path word is waiting on stall
  bit          m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_inst;

  // ROM responder state (survives DUT reset)
  bit          rom_out = 1'b0;
  int          rom_delay = 0;
  logic [31:0] rom_e_addr = '0;

  // Random knobs
  int gnt_pct = 100;
  int max_delay = 0;
  int stall_pct = 0;
  int br_pct = 0;
  int fl_pct = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output that is meaningful this cycle against the model
  task automatic check_outputs();
    logic exp_req;
    exp_req = !m_busy && !m_held;
    chk1("rom_req", rom_req, exp_req);
    if (exp_req) chk("rom_addr", rom_addr, m_pc);
    chk1("if_valid", if_valid, m_valid);
    if (m_valid) begin
      chk("if_addr", if_addr, m_addr);
      chk("if_inst", if_inst, m_inst);
    end
  endtask

  task automatic deliver(input logic [31:0] a);
    m_valid = 1'b1;
    m_addr  = a;
    m_inst  = rom_word(a);
  endtask

  // Advance the model by one clock edge using the inputs that were driven
  task automatic model_update(input logic [31:0] gaddr);
    bit          redir;
    logic [31:0] tgt;
    redir = flush || (branch_flag && !stall);
    tgt   = flush ? exc_pc : branch_addr;

    if (m_held && !redir && !stall) begin
      deliver(exp_q.pop_front());
      m_held = 1'b0;
    end

    if (rom_rvalid) begin
      rom_out = 1'b0;
      if (m_busy) begin
        m_busy = 1'b0;
        // Anything still queued survived every redirect since its grant
        if (!redir && exp_q.size() > 0) begin
          if (!stall) deliver(exp_q.pop_front());
          else m_held = 1'b1;
        end
      end
    end

    if (rom_gnt) begin
      rom_out    = 1'b1;
      rom_delay  = int'($urandom_range(max_delay, 0));
      rom_e_addr = gaddr;
      m_busy     = 1'b1;
      exp_q.push_back(m_pc);
      m_pc       = m_pc + 32'd4;
    end

    if (redir) begin
      m_pc = tgt;
      exp_q.delete();
      m_held = 1'b0;
    end

    if (flush) m_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- drivers
  // Called at a negedge: check, drive one cycle of inputs, let the edge pass.
  // gmode/rmode: 0 random, 1 force on (when legal), 2 force off.
  task automatic step(input logic st, input logic fl, input logic [31:0] ea,
                      input logic br, input logic [31:0] ba,
                      input int gmode, input int rmode);
    logic [31:0] gaddr;
    check_outputs();
    stall       = st;
    flush       = fl;
    exc_pc      = ea;
    branch_flag = br;
    branch_addr = ba;
    rom_rvalid  = 1'b0;
    rom_rdata   = $urandom();
    if (rom_out) begin
      if (rmode == 1 || (rmode == 0 && rom_delay == 0)) begin
        rom_rvalid = 1'b1;
        rom_rdata  = rom_word(rom_e_addr);
      end else if (rmode == 0) begin
        rom_delay--;
      end
    end
    rom_gnt = 1'b0;
    if (rom_req && !rom_out) begin
      if (gmode == 1) rom_gnt = 1'b1;
      else if (gmode == 0 && int'($urandom_range(99, 0)) < gnt_pct) rom_gnt = 1'b1;
    end
    gaddr = rom_addr;
    @(posedge clk);
    model_update(gaddr);
    @(negedge clk);
  endtask

  task automatic go(input int gmode, input int rmode);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, gmode, rmode);
  endtask

  task automatic do_flush(input logic [31:0] ea);
    step(1'b0, 1'b1, ea, 1'b0, 32'h0, 2, 2);
  endtask

  // Fetch one word straight through (grant, then response) with stall=0
  task automatic fetch_one();
    go(1, 2);
    go(2, 1);
  endtask

  // Called at a negedge; asynchronous assert, checks reset values, releases
  task automatic do_reset();
    rst = 1'b1;
    rom_gnt = 1'b0;
    rom_rvalid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    branch_flag = 1'b0;
    #1;
    chk1("rst_rom_req", rom_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_addr", if_addr, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_rom_addr", rom_addr, RESET_PC);
    m_pc = RESET_PC;
    m_busy = 1'b0;
    m_held = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic random_phase(input int n, input int gp, input int md,
                              input int sp, input int bp, input int fp);
    logic        st, fl, br;
    logic [31:0] ea, ba;
    gnt_pct = gp; max_delay = md; stall_pct = sp; br_pct = bp; fl_pct = fp;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(799, 0) == 0) do_reset();
      st = int'($urandom_range(99, 0)) < stall_pct;
      fl = int'($urandom_range(99, 0)) < fl_pct;
      br = int'($urandom_range(99, 0)) < br_pct;
      ea = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      ba = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      step(st, fl, ea, br, ba, 0, 0);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    @(negedge clk);
    do_reset();

    // Straight-line fetch, one word per two cycles
    chk("a_first_addr", rom_addr, 32'hBFC0_0000);
    go(1, 2);
    chk1("a_valid_c1", if_valid, 1'b0);
    go(2, 1);
    chk1("a_valid_c2", if_valid, 1'b1);
    chk("a_if_addr0", if_addr, 32'hBFC0_0000);
    chk("a_rom_addr1", rom_addr, 32'hBFC0_0004);
    fetch_one();
    chk("a_if_addr1", if_addr, 32'hBFC0_0004);
    chk("a_rom_addr2", rom_addr, 32'hBFC0_0008);
    fetch_one();
    chk("a_if_addr2", if_addr, 32'hBFC0_0008);

    // Response for 0x100 lands during a three-cycle stall
    do_flush(32'h0000_00FC);
    chk1("b_flush_valid", if_valid, 1'b0);
    fetch_one();
    chk("b_if_addr_fc", if_addr, 32'h0000_00FC);
    go(1, 2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2, 1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0800, 2, 2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2, 2);
    chk("b_frozen_addr", if_addr, 32'h0000_00FC);
    chk1("b_hold_req", rom_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 2);
    chk("b_release_addr", if_addr, 32'h0000_0100);
    chk("b_next_fetch", rom_addr, 32'h0000_0104);

    // Branch in ID while the fetch of 0x204 waits for its response
    do_flush(32'h0000_0200);
    fetch_one();
    chk("c_delay_slot", if_addr, 32'h0000_0200);
    go(1, 2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 2, 2);
    chk("c_slot_kept", if_addr, 32'h0000_0200);
    chk1("c_slot_valid", if_valid, 1'b1);
    go(2, 1);
    chk("c_slot_after_drop", if_addr, 32'h0000_0200);
    chk("c_target_fetch", rom_addr, 32'h0000_0400);
    fetch_one();
    chk("c_target_delivered", if_addr, 32'h0000_0400);

    // Same, but the 0x204 response arrives in the branch cycle
    do_flush(32'h0000_0200);
    fetch_one();
    go(1, 2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0400, 2, 1);
    chk1("d_req", rom_req, 1'b1);
    chk("d_target_fetch", rom_addr, 32'h0000_0400);
    chk("d_slot_kept", if_addr, 32'h0000_0200);
    fetch_one();
    chk("d_target_delivered", if_addr, 32'h0000_0400);

    // Flush and branch together: flush wins
    step(1'b0, 1'b1, 32'h8000_0180, 1'b1, 32'h0000_0400, 2, 2);
    chk1("e_valid_cleared", if_valid, 1'b0);
    chk("e_exc_fetch", rom_addr, 32'h8000_0180);
    fetch_one();
    chk("e_exc_delivered", if_addr, 32'h8000_0180);

    // Reset while waiting, stray response after release
    go(1, 2);
    do_reset();
    chk("f_reset_fetch", rom_addr, RESET_PC);
    go(2, 1);
    chk1("f_stray_valid", if_valid, 1'b0);
    chk1("f_stray_req", rom_req, 1'b1);
    go(1, 2);
    chk1("f_wait_valid", if_valid, 1'b0);
    go(2, 1);
    chk1("f_new_valid", if_valid, 1'b1);
    chk("f_new_addr", if_addr, RESET_PC);

    // Randomized traffic
    random_phase(300, 100, 0, 0, 0, 0);
    random_phase(3000, 60, 3, 30, 5, 2);
    random_phase(3000, 80, 1, 50, 10, 5);
    random_phase(3000, 30, 4, 10, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
